mem_arbiter: RTL and testbench

- Shares the single memory port (MAR load, memEN, RW, MFC handshake) between two requesters: the instruction-fetch sequencer (IF, read-only) and the execute-stage load/store unit (EX, read/write).
- Arbitrates round-robin, sequences each access, captures read data, and flags accesses where MFC never arrives.
- Sits between the control FSMs and the memory/MAR/MDR datapath.

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory port arbiter.
// The slave modport faces the arbiter; the master modport faces the requesters and the memory.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_grant;
  logic          if_done;

  logic          ex_req;
  logic          ex_we;
  logic [AW-1:0] ex_addr;
  logic [DW-1:0] ex_wdata;
  logic          ex_grant;
  logic          ex_done;

  logic [DW-1:0] rdata;
  logic          err;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          MARin;
  logic          memEN;
  logic          RW;
  logic          MFC;

  modport slave (
    input  if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_rdata, MFC,
    output if_grant, if_done, ex_grant, ex_done, rdata, err,
           mem_addr, mem_wdata, MARin, memEN, RW
  );

  modport master (
    output if_req, if_addr, ex_req, ex_we, ex_addr, ex_wdata, mem_rdata, MFC,
    input  if_grant, if_done, ex_grant, ex_done, rdata, err,
           mem_addr, mem_wdata, MARin, memEN, RW
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one MAR/memEN/RW/MFC memory port between the IF
// sequencer (read-only) and the EX load/store unit, with an MFC timeout abort.
module mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_EX = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP    = 2'd1,
    S_ACCESS   = 2'd2,
    S_COMPLETE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_owner_q, last_owner_d;
  logic          rw_q, rw_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          if_grant_q, if_grant_d;
  logic          ex_grant_q, ex_grant_d;
  logic          if_done_q, if_done_d;
  logic          ex_done_q, ex_done_d;
  logic          marin_q, marin_d;
  logic          memen_q, memen_d;
  logic          rw_out_q, rw_out_d;
  logic          grant_ex;

  // Next state, transaction latch and registered Moore outputs decoded from the next state.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rw_d         = rw_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    grant_ex     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.ex_req) begin
          // On a tie the requester that did not own the port last time wins.
          grant_ex    = bus.ex_req && (!bus.if_req || (last_owner_q == OWN_IF));
          owner_d     = grant_ex ? OWN_EX : OWN_IF;
          rw_d        = grant_ex ? ~bus.ex_we : 1'b1;
          mem_addr_d  = grant_ex ? bus.ex_addr : bus.if_addr;
          mem_wdata_d = grant_ex ? bus.ex_wdata : '0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.MFC) begin
          if (rw_q) rdata_d = bus.mem_rdata;
          state_d = S_COMPLETE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      S_COMPLETE: begin
        last_owner_d = owner_q;
        cnt_d        = '0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if_grant_d = (state_d != S_IDLE) && (owner_d == OWN_IF);
    ex_grant_d = (state_d != S_IDLE) && (owner_d == OWN_EX);
    if_done_d  = (state_d == S_COMPLETE) && (owner_d == OWN_IF);
    ex_done_d  = (state_d == S_COMPLETE) && (owner_d == OWN_EX);
    marin_d    = (state_d == S_SETUP);
    memen_d    = (state_d == S_ACCESS);
    rw_out_d   = (state_d == S_ACCESS) && rw_d;
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_EX;
      rw_q         <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      if_grant_q   <= 1'b0;
      ex_grant_q   <= 1'b0;
      if_done_q    <= 1'b0;
      ex_done_q    <= 1'b0;
      marin_q      <= 1'b0;
      memen_q      <= 1'b0;
      rw_out_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rw_q         <= rw_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      if_grant_q   <= if_grant_d;
      ex_grant_q   <= ex_grant_d;
      if_done_q    <= if_done_d;
      ex_done_q    <= ex_done_d;
      marin_q      <= marin_d;
      memen_q      <= memen_d;
      rw_out_q     <= rw_out_d;
    end
  end

  assign bus.if_grant  = if_grant_q;
  assign bus.ex_grant  = ex_grant_q;
  assign bus.if_done   = if_done_q;
  assign bus.ex_done   = ex_done_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.MARin     = marin_q;
  assign bus.memEN     = memen_q;
  assign bus.RW        = rw_out_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a memory responder with programmable MFC delay and a
// scoreboard of expected transactions checked when each done pulse appears.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;
  localparam logic [15:0] RD_KEY = 16'hBEAF;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;   // 0 = IF, 1 = EX
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;      // 1 = read
    logic [15:0] rdata;
    logic        err;
    int          acc;     // expected memEN cycles
  } txn_t;

  txn_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   mfc_delay    = 0;
  bit   mfc_force    = 1'b0;
  int   resp_cnt     = 0;
  int   mon_acc      = 0;
  logic [15:0] model_rdata = '0;

  // Memory returns address XOR a key, so 0x0040 reads back as 0xBEEF.
  assign bus.mem_rdata = bus.mem_addr ^ RD_KEY;

  always @(negedge clk) begin
    if (bus.memEN) begin
      resp_cnt = resp_cnt + 1;
      bus.MFC  = mfc_force || ((mfc_delay != 0) && (resp_cnt == mfc_delay));
    end else begin
      resp_cnt = 0;
      bus.MFC  = mfc_force;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic owner, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic rw, input logic [15:0] rd, input logic e, input int acc);
    txn_t t;
    t.owner = owner; t.addr = addr; t.wdata = wdata; t.rw = rw;
    t.rdata = rd;    t.err = e;     t.acc = acc;
    sb.push_back(t);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(bus.if_done || bus.ex_done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(bus.if_done | bus.ex_done), 32'd1);
  endtask

  // Scoreboard monitor: setup contents, access length, RW, done owner, err and rdata.
  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      check("grant_excl", 32'(bus.if_grant & bus.ex_grant), 32'd0);
      if (bus.MARin) begin
        mon_acc = 0;
        check("sb_nonempty_setup", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("setup_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
          if (!sb[0].rw) check("setup_wdata", 32'(bus.mem_wdata), 32'(sb[0].wdata));
        end
      end
      if (bus.memEN) begin
        mon_acc++;
        if (sb.size() != 0) check("access_rw", 32'(bus.RW), 32'(sb[0].rw));
      end
      if (bus.if_done || bus.ex_done) begin
        check("sb_nonempty_done", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          t = sb.pop_front();
          check("done_if", 32'(bus.if_done), 32'(!t.owner));
          check("done_ex", 32'(bus.ex_done), 32'(t.owner));
          check("done_err", 32'(bus.err), 32'(t.err));
          check("done_rdata", 32'(bus.rdata), 32'(t.rdata));
          check("access_cycles", 32'(mon_acc), 32'(t.acc));
        end
      end else begin
        check("err_quiet", 32'(bus.err), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ex_req = 1'b0; bus.ex_we = 1'b0; bus.ex_addr = '0; bus.ex_wdata = '0;

    // Reset held for two edges: everything zero.
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({bus.if_grant, bus.if_done, bus.ex_grant, bus.ex_done,
                           bus.err, bus.MARin, bus.memEN, bus.RW}), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_quiet", 32'({bus.if_grant, bus.ex_grant, bus.MARin, bus.memEN}), 32'd0);
    end

    // IF read of 0x0040, MFC in the first access cycle.
    mfc_delay = 1;
    bus.if_addr = 16'h0040; bus.if_req = 1'b1;
    push(1'b0, 16'h0040, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1);
    @(negedge clk);
    check("if_setup_marin", 32'(bus.MARin), 32'd1);
    check("if_setup_grant", 32'(bus.if_grant), 32'd1);
    check("if_setup_addr", 32'(bus.mem_addr), 32'h0040);
    check("if_setup_memen", 32'(bus.memEN), 32'd0);
    @(negedge clk);
    check("if_access", 32'({bus.memEN, bus.RW, bus.MARin}), 32'b110);
    @(negedge clk);
    check("if_done_n3", 32'(bus.if_done), 32'd1);
    check("if_rdata", 32'(bus.rdata), 32'hBEEF);
    check("if_complete_memen", 32'(bus.memEN), 32'd0);
    bus.if_req = 1'b0;
    model_rdata = 16'hBEEF;
    @(negedge clk);
    check("if_back_idle", 32'({bus.if_grant, bus.if_done}), 32'd0);

    // EX write of 0x00AA to 0x1234, MFC after five access cycles.
    mfc_delay = 5;
    bus.ex_we = 1'b1; bus.ex_addr = 16'h1234; bus.ex_wdata = 16'h00AA; bus.ex_req = 1'b1;
    push(1'b1, 16'h1234, 16'h00AA, 1'b0, model_rdata, 1'b0, 5);
    @(negedge clk);
    bus.ex_addr = 16'hFFFF; bus.ex_wdata = 16'h5555; bus.ex_we = 1'b0;
    wait_done("exw");
    check("exw_rdata_kept", 32'(bus.rdata), 32'(model_rdata));
    check("exw_mem_wdata", 32'(bus.mem_wdata), 32'h00AA);
    bus.ex_req = 1'b0;
    @(negedge clk);

    // Both requesters held for four transactions: IF, EX, IF, EX.
    mfc_delay = 1;
    bus.ex_we = 1'b0; bus.ex_addr = 16'h2000; bus.if_addr = 16'h0080;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push(1'b0, 16'h0080, 16'h0, 1'b1, 16'h0080 ^ RD_KEY, 1'b0, 1);
      else            push(1'b1, 16'h2000, 16'h0, 1'b1, 16'h2000 ^ RD_KEY, 1'b0, 1);
    end
    bus.if_req = 1'b1; bus.ex_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done("rr");
      check("rr_owner", 32'(bus.ex_done), 32'(i % 2));
      if (i == 3) begin
        bus.if_req = 1'b0; bus.ex_req = 1'b0;
      end
      @(negedge clk);
      check("rr_idle_gap", 32'({bus.if_grant, bus.ex_grant, bus.MARin}), 32'd0);
    end
    model_rdata = 16'h2000 ^ RD_KEY;

    // MFC outside an access does nothing.
    mfc_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_mfc", 32'({bus.memEN, bus.MARin, bus.if_done, bus.ex_done}), 32'd0);
      check("stray_mfc_rdata", 32'(bus.rdata), 32'(model_rdata));
    end
    mfc_force = 1'b0;

    // IF read where MFC never comes: aborts after TIMEOUT access cycles.
    mfc_delay = 0;
    bus.if_addr = 16'h0300; bus.if_req = 1'b1;
    push(1'b0, 16'h0300, 16'h0, 1'b1, model_rdata, 1'b1, int'(TO));
    wait_done("to");
    check("to_err", 32'({bus.if_done, bus.err}), 32'b11);
    check("to_rdata_kept", 32'(bus.rdata), 32'(model_rdata));
    bus.if_req = 1'b0;
    @(negedge clk);
    check("to_err_clear", 32'(bus.err), 32'd0);

    // Normal read after the timeout.
    mfc_delay = 2;
    bus.if_addr = 16'h0042; bus.if_req = 1'b1;
    push(1'b0, 16'h0042, 16'h0, 1'b1, 16'h0042 ^ RD_KEY, 1'b0, 2);
    wait_done("post_to");
    check("post_to_err", 32'(bus.err), 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);

    // EX read aborted by reset in its third access cycle; IF pending meanwhile.
    mfc_delay = 0;
    bus.ex_we = 1'b0; bus.ex_addr = 16'h0500; bus.ex_req = 1'b1;
    push(1'b1, 16'h0500, 16'h0, 1'b1, 16'h0, 1'b0, 0);
    n = 0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (bus.memEN) n++;
    end
    check("rst_mid_reached", 32'(n), 32'd3);
    #1;
    void'(sb.pop_front());
    rst = 1'b0;
    mfc_delay = 1;
    bus.if_addr = 16'h0600; bus.if_req = 1'b1;
    @(negedge clk);
    check("rst_mid_quiet", 32'({bus.memEN, bus.if_grant, bus.ex_grant, bus.ex_done, bus.if_done}), 32'd0);
    check("rst_mid_rdata", 32'(bus.rdata), 32'd0);
    rst = 1'b1;
    push(1'b0, 16'h0600, 16'h0, 1'b1, 16'h0600 ^ RD_KEY, 1'b0, 1);
    push(1'b1, 16'h0500, 16'h0, 1'b1, 16'h0500 ^ RD_KEY, 1'b0, 1);
    wait_done("post_rst_if");
    check("post_rst_if_first", 32'(bus.if_done), 32'd1);
    bus.if_req = 1'b0;
    wait_done("post_rst_ex");
    check("post_rst_ex_second", 32'(bus.ex_done), 32'd1);
    bus.ex_req = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
